// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem read, 2-entry queue to decode, PC redirect with stale-fetch flush.
// Output valid one cycle after imem_rvalid; issue stalls when the queue is full, head holds while out_ready=0.
module fetch_unit #(
  parameter int                ADDR_W   = 8,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [3:0]         out_opcode,
  output logic [ADDR_W-1:0]  out_pc
);

  typedef enum logic {ISSUE, WAIT} state_t;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  pc, pc_nxt;
  logic [ADDR_W-1:0]  req_pc, req_pc_nxt;
  logic               discard, discard_nxt;
  logic               issue, push, pop;

  logic [INSTR_W-1:0] q_instr [2];
  logic [ADDR_W-1:0]  q_pc    [2];
  logic               head, tail;
  logic [1:0]         count;

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    req_pc_nxt  = req_pc;
    discard_nxt = discard;
    issue       = 1'b0;
    push        = 1'b0;
    if (redirect_valid) begin
      pc_nxt = redirect_pc;
      // A response still in flight belongs to the old stream: drop it now or mark it for dropping.
      if (state == WAIT) begin
        if (imem_rvalid) begin
          discard_nxt = 1'b0;
          state_nxt   = ISSUE;
        end else begin
          discard_nxt = 1'b1;
        end
      end
    end else begin
      case (state)
        ISSUE: begin
          if (count != 2'd2) begin
            issue      = 1'b1;
            req_pc_nxt = pc;
            pc_nxt     = pc + PC_ONE;
            state_nxt  = WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            push        = !discard;
            discard_nxt = 1'b0;
            state_nxt   = ISSUE;
          end
        end
        default: state_nxt = ISSUE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ISSUE;
      pc      <= RESET_PC;
      req_pc  <= '0;
      discard <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      req_pc  <= req_pc_nxt;
      discard <= discard_nxt;
    end
  end

  // Request is masked while in reset so it drops the instant rst_n falls.
  assign imem_req  = issue && rst_n;
  assign imem_addr = pc;

  assign pop = out_valid && out_ready && !redirect_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else if (redirect_valid) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        q_instr[tail] <= imem_rdata;
        q_pc[tail]    <= req_pc;
        tail          <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign out_valid  = (count != 2'd0);
  assign out_instr  = q_instr[head];
  assign out_pc     = q_pc[head];
  assign out_opcode = q_instr[head][INSTR_W-1 -: 4];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: directed scenarios push expected requests/outputs, monitors compare.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [15:0] imem_rdata  = 16'hDEAD;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [3:0]  out_opcode;
  logic [7:0]  out_pc;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int mem_k  = 1;

  typedef struct {
    int         cyc;
    logic [7:0] pc;
  } exp_t;

  exp_t exp_req[$];
  exp_t exp_out[$];
  exp_t er, eo;
  logic [7:0] mem_a;
  bit         mem_ok;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_opcode     (out_opcode),
    .out_pc         (out_pc)
  );

  always #5 clk = ~clk;

  // Cycle index of the upcoming rising edge as seen from the preceding falling edge.
  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic void exp_r(input logic [7:0] pc, input int c);
    exp_req.push_back('{cyc: c, pc: pc});
  endfunction

  function automatic void exp_o(input logic [7:0] pc, input int c);
    exp_out.push_back('{cyc: c, pc: pc});
  endfunction

  task automatic drained(input string tag);
    chk({tag, "_req_left"}, exp_req.size(), 0);
    chk({tag, "_out_left"}, exp_out.size(), 0);
    exp_req.delete();
    exp_out.delete();
  endtask

  task automatic do_reset(input bit check_now);
    rst_n = 1'b0;
    if (check_now) begin
      #1;
      chk("async_rst_out_valid", out_valid, 0);
      chk("async_rst_imem_req",  imem_req,  0);
      chk("async_rst_out_instr", out_instr, 0);
      chk("async_rst_out_pc",    out_pc,    0);
    end
    tick(2);
    rst_n = 1'b1;
  endtask

  // Memory: accepts a request at the edge, returns {addr, 8'hA0} k edges later; aborted by reset.
  always begin
    @(negedge clk);
    if (rst_n && imem_req) begin
      mem_a  = imem_addr;
      mem_ok = 1'b1;
      for (int i = 0; i < mem_k; i++) begin
        @(posedge clk);
        if (!rst_n) mem_ok = 1'b0;
      end
      #1;
      if (mem_ok && rst_n) begin
        imem_rvalid = 1'b1;
        imem_rdata  = {mem_a, 8'hA0};
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        imem_rdata  = 16'hDEAD;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && imem_req) begin
      if (exp_req.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL req_unexpected: addr %0h at cycle %0d, no request expected", imem_addr, cyc);
      end else begin
        er = exp_req.pop_front();
        chk("req_addr",  imem_addr, er.pc);
        chk("req_cycle", cyc,       er.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_out.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_unexpected: pc %0h at cycle %0d, no output expected", out_pc, cyc);
      end else begin
        eo = exp_out.pop_front();
        chk("out_pc",     out_pc,     eo.pc);
        chk("out_instr",  out_instr,  {eo.pc, 8'hA0});
        chk("out_opcode", out_opcode, eo.pc[7:4]);
        chk("out_cycle",  cyc,        eo.cyc);
      end
    end
  end

  initial begin
    rst_n          = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    #2;
    chk("reset_imem_req",   imem_req,   0);
    chk("reset_out_valid",  out_valid,  0);
    chk("reset_out_instr",  out_instr,  0);
    chk("reset_out_pc",     out_pc,     0);
    chk("reset_out_opcode", out_opcode, 0);
    tick(2);
    rst_n = 1'b1;

    // Backpressure: two entries buffered, fetch stops, resumes at PC 2 once drained.
    mem_k = 1; out_ready = 1'b0;
    exp_r(8'h00, 0); exp_r(8'h01, 2); exp_r(8'h02, 9);
    exp_o(8'h00, 8); exp_o(8'h01, 9);
    tick(6);
    #4;
    chk("stall_out_valid", out_valid, 1);
    chk("stall_out_pc",    out_pc,    8'h00);
    chk("stall_out_instr", out_instr, 16'h00A0);
    tick(2);
    out_ready = 1'b1;
    tick(2);
    drained("bp");
    do_reset(1'b0);

    // Redirect during WAIT (twice while discard pending): the 0x05 response is dropped.
    mem_k = 3; out_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 8'h05;
    exp_r(8'h05, 1); exp_r(8'h40, 5); exp_r(8'h41, 9);
    exp_o(8'h40, 9);
    tick(1); redirect_valid = 1'b0;
    tick(1); redirect_valid = 1'b1; redirect_pc = 8'h20;
    tick(1); redirect_pc = 8'h40;
    tick(1); redirect_valid = 1'b0;
    tick(6);
    drained("rd_wait");
    do_reset(1'b0);

    // Redirect coincident with rvalid while one entry is queued.
    mem_k = 1; out_ready = 1'b0;
    exp_r(8'h00, 0); exp_r(8'h01, 2); exp_r(8'h80, 4); exp_r(8'h81, 6);
    exp_o(8'h80, 6);
    tick(3);
    redirect_valid = 1'b1; redirect_pc = 8'h80;
    #4;
    chk("pre_flush_out_valid", out_valid, 1);
    chk("pre_flush_out_pc",    out_pc,    8'h00);
    tick(1);
    redirect_valid = 1'b0;
    #4;
    chk("flush_out_valid", out_valid, 0);
    tick(2);
    out_ready = 1'b1;
    tick(1);
    drained("rd_rvalid");
    do_reset(1'b0);

    // PC wrap from 0xFF to 0x00.
    mem_k = 1; out_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 8'hFF;
    exp_r(8'hFF, 1); exp_r(8'h00, 3); exp_r(8'h01, 5);
    exp_o(8'hFF, 3); exp_o(8'h00, 5);
    tick(1); redirect_valid = 1'b0;
    tick(5);
    drained("wrap");
    do_reset(1'b0);

    // Mid-cycle reset with a full queue.
    mem_k = 1; out_ready = 1'b0;
    exp_r(8'h00, 0); exp_r(8'h01, 2);
    tick(4);
    #2;
    chk("full_out_valid", out_valid, 1);
    drained("rst_full");
    do_reset(1'b1);

    // Mid-cycle reset while a discard is pending.
    mem_k = 3; out_ready = 1'b1;
    exp_r(8'h00, 0);
    tick(1); redirect_valid = 1'b1; redirect_pc = 8'h10;
    tick(1); redirect_valid = 1'b0;
    #2;
    drained("rst_discard");
    do_reset(1'b1);

    // Sequential fetch at k=1; first response must not be dropped after the reset above.
    mem_k = 1; out_ready = 1'b1;
    exp_r(8'h00, 0); exp_r(8'h01, 2); exp_r(8'h02, 4); exp_r(8'h03, 6); exp_r(8'h04, 8);
    exp_o(8'h00, 2); exp_o(8'h01, 4); exp_o(8'h02, 6); exp_o(8'h03, 8);
    tick(9);
    drained("seq");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
